// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: tick-based dino jump physics with input sync, press detection and run animation
// Ports: clk, reset (async, active-high), controller_report[7:0] (raw; bit0 jump, bit5 duck),
//        game_over (sync) -> dino_y[10:0], airborne, run_frame, ducking, tick (physics pulse).
// Optional ducking pose is built when DINO_DUCK_EN is defined.
module dino_jump_ctrl #(
  parameter int GROUND_Y    = 348,
  parameter int MIN_Y       = 100,
  parameter int JUMP_V0     = 12,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 16,
  parameter int TICK_CYCLES = 500000,
  parameter int RUN_DIV     = 8,
  parameter int DUCK_OFFSET = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  controller_report,
  input  logic        game_over,
  output logic [10:0] dino_y,
  output logic        airborne,
  output logic        run_frame,
  output logic        ducking,
  output logic        tick
);
  localparam logic [1:0] GROUND = 2'd0, ASCEND = 2'd1, DESCEND = 2'd2;
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int RW = $clog2(RUN_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_DIV - 1);
  localparam logic [11:0] GY = 12'(GROUND_Y), MY = 12'(MIN_Y);
  localparam logic [5:0] V0 = 6'(JUMP_V0), GR = 6'(GRAVITY), MF = 6'(MAX_FALL);
  logic [1:0] jump_sync, state, state_n;
  logic jump_prev, jump_edge, pending, pending_n, game_over_q, replay, unused;
  logic [11:0] y, y_n;
  logic [5:0] vel, vel_n, fall_v;
  logic [6:0] fall_sum;
  logic [12:0] ceil_up, ceil_v0, land;
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] run_cnt;
  assign tick = (tick_cnt == TICK_LAST) & ~game_over;
  assign replay = game_over_q & ~game_over;
  assign jump_edge = jump_sync[1] & ~jump_prev;
  assign airborne = state != GROUND;
  // presses only count on the ground; pending survives until the next tick consumes it
  assign pending_n = ~game_over & ~replay & ((pending & ~tick) | (jump_edge & ~airborne & ~ducking));
`ifdef DINO_DUCK_EN
  logic [1:0] duck_sync;
  logic duck_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      duck_sync <= '0;
      duck_q <= 1'b0;
    end else begin
      duck_sync <= {duck_sync[0], controller_report[5]};
      duck_q <= duck_sync[1];
    end
  assign ducking = duck_q & (state == GROUND);
  assign dino_y = y[10:0] + (ducking ? 11'(DUCK_OFFSET) : 11'd0);
  assign unused = ^{controller_report[7:6], controller_report[4:1], y[11]};
`else
  assign ducking = 1'b0;
  assign dino_y = y[10:0];
  assign unused = ^{controller_report[7:1], y[11], 32'(DUCK_OFFSET)};
`endif
  // ceiling tests compare y against MIN_Y + step so nothing ever underflows
  always_comb begin
    fall_sum = 7'(vel) + 7'(GR);
    fall_v = (fall_sum > 7'(MF)) ? MF : fall_sum[5:0];
    ceil_up = 13'(MY) + 13'(vel);
    ceil_v0 = 13'(MY) + 13'(V0);
    land = 13'(y) + 13'(fall_v);
    state_n = state;
    y_n = y;
    vel_n = vel;
    if (tick)
      case (state)
        GROUND:
          if (pending) begin
            if (13'(y) < ceil_v0) begin
              state_n = DESCEND;
              y_n = MY;
              vel_n = '0;
            end else begin
              y_n = y - 12'(V0);
              state_n = (V0 <= GR) ? DESCEND : ASCEND;
              vel_n = (V0 <= GR) ? 6'd0 : V0 - GR;
            end
          end
        ASCEND:
          if (13'(y) < ceil_up) begin
            state_n = DESCEND;
            y_n = MY;
            vel_n = '0;
          end else begin
            y_n = y - 12'(vel);
            state_n = (vel <= GR) ? DESCEND : ASCEND;
            vel_n = (vel <= GR) ? 6'd0 : vel - GR;
          end
        DESCEND:
          if (land >= 13'(GY)) begin
            state_n = GROUND;
            y_n = GY;
            vel_n = '0;
          end else begin
            y_n = land[11:0];
            vel_n = fall_v;
          end
        default: begin
          state_n = GROUND;
          y_n = GY;
          vel_n = '0;
        end
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      jump_sync <= '0;
      jump_prev <= 1'b0;
      game_over_q <= 1'b0;
      pending <= 1'b0;
      state <= GROUND;
      y <= GY;
      vel <= '0;
      tick_cnt <= '0;
      run_cnt <= '0;
      run_frame <= 1'b0;
    end else begin
      jump_sync <= {jump_sync[0], controller_report[0]};
      jump_prev <= jump_sync[1];
      game_over_q <= game_over;
      pending <= pending_n;
      if (game_over) begin
        tick_cnt <= '0;
      end else if (replay) begin
        state <= GROUND;
        y <= GY;
        vel <= '0;
        tick_cnt <= '0;
        run_cnt <= '0;
        run_frame <= 1'b0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        state <= state_n;
        y <= y_n;
        vel <= vel_n;
        if (tick && state == GROUND) begin
          run_cnt <= (run_cnt == RUN_LAST) ? '0 : run_cnt + RW'(1);
          run_frame <= run_frame ^ (run_cnt == RUN_LAST);
        end
      end
    end
endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb_dino_jump_ctrl: scoreboard bench for dino_jump_ctrl with a default and a low-ceiling instance
module tb_dino_jump_ctrl;
  typedef struct {
    logic [10:0] y;
    logic air;
    logic rf;
    logic rf_en;
  } exp_t;
`ifdef DINO_DUCK_EN
  localparam int DY = 364, DK = 1;
`else
  localparam int DY = 348, DK = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, game_over = 1'b0;
  logic [7:0] report = '0;
  logic [10:0] y0, y1;
  logic air0, air1, rf0, rf1, dk0, dk1, tk0, tk1;
  exp_t q0[$], q1[$];
  int n_checks = 0, n_fail = 0;
  int arc [24] = '{336, 325, 315, 306, 298, 291, 285, 280, 276, 273, 271, 270,
                   271, 273, 276, 280, 285, 291, 298, 306, 315, 325, 336, 348};
  int ceil_arc [15] = '{336, 325, 315, 306, 300, 301, 303, 306, 310, 315, 321, 328, 336, 345, 348};

  dino_jump_ctrl #(.TICK_CYCLES(4)) u0 (
    .clk(clk), .reset(reset), .controller_report(report), .game_over(game_over),
    .dino_y(y0), .airborne(air0), .run_frame(rf0), .ducking(dk0), .tick(tk0));
  dino_jump_ctrl #(.TICK_CYCLES(4), .MIN_Y(300)) u1 (
    .clk(clk), .reset(reset), .controller_report(report), .game_over(game_over),
    .dino_y(y1), .airborne(air1), .run_frame(rf1), .ducking(dk1), .tick(tk1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int inst, input int y, input bit air, input bit rf, input bit rf_en);
    exp_t e;
    e.y = 11'(y);
    e.air = air;
    e.rf = rf;
    e.rf_en = rf_en;
    if (inst == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic ground(input int inst, input int n, input int y);
    for (int i = 0; i < n; i++) push(inst, y, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tk0 !== 1'b1 && n < 12);
    chk("tick_wait", {31'd0, tk0}, 1);
  endtask

  task automatic pulse_jump();
    report[0] = 1'b1;
    @(negedge clk);
    report[0] = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tk0 === 1'b1) begin
        @(negedge clk);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("u0_tick_y", {21'd0, y0}, {21'd0, e.y});
          chk("u0_tick_airborne", {31'd0, air0}, {31'd0, e.air});
          if (e.rf_en) chk("u0_tick_run_frame", {31'd0, rf0}, {31'd0, e.rf});
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tk1 === 1'b1) begin
        @(negedge clk);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("u1_tick_y", {21'd0, y1}, {21'd0, e.y});
          chk("u1_tick_airborne", {31'd0, air1}, {31'd0, e.air});
          if (e.rf_en) chk("u1_tick_run_frame", {31'd0, rf1}, {31'd0, e.rf});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    chk("rst_y0", {21'd0, y0}, 348);
    chk("rst_air0", {31'd0, air0}, 0);
    chk("rst_rf0", {31'd0, rf0}, 0);
    chk("rst_duck0", {31'd0, dk0}, 0);
    chk("rst_tick0", {31'd0, tk0}, 0);
    chk("rst_y1", {21'd0, y1}, 348);
    // run animation after reset: toggles at ticks 8, 16, 24
    for (int k = 1; k <= 24; k++) begin
      push(0, 348, 1'b0, (k >= 8 && k < 16) || k == 24, 1'b1);
      push(1, 348, 1'b0, (k >= 8 && k < 16) || k == 24, 1'b1);
    end
    reset = 1'b0;
    repeat (24) wait_tick();
    // held press for 50 ticks (200 cycles): one jump at tick 25
    report[0] = 1'b1;
    for (int i = 0; i < 24; i++) push(0, arc[i], i < 23, 1'b1, 1'b1);
    ground(0, 26, 348);
    for (int i = 0; i < 15; i++) push(1, ceil_arc[i], i < 14, 1'b1, 1'b1);
    ground(1, 35, 348);
    repeat (50) wait_tick();
    report[0] = 1'b0;
    // second jump at tick 76, extra press at flight tick 5 ignored
    ground(0, 1, 348);
    ground(1, 1, 348);
    wait_tick();
    pulse_jump();
    for (int i = 0; i < 24; i++) push(0, arc[i], i < 23, 1'b0, 1'b0);
    ground(0, 5, 348);
    for (int i = 0; i < 15; i++) push(1, ceil_arc[i], i < 14, 1'b0, 1'b0);
    ground(1, 14, 348);
    repeat (5) wait_tick();
    pulse_jump();
    repeat (24) wait_tick();
    // third jump, game over after flight tick 6
    pulse_jump();
    for (int i = 0; i < 6; i++) push(0, arc[i], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) push(1, ceil_arc[i], 1'b1, 1'b0, 1'b0);
    repeat (6) wait_tick();
    @(negedge clk);
    game_over = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tk0 === 1'b1 || tk1 === 1'b1) seen++;
      if (i == 5) report[0] = 1'b1;
      if (i == 6) report[0] = 1'b0;
    end
    chk("go_ticks", seen, 0);
    chk("go_y0", {21'd0, y0}, 291);
    chk("go_air0", {31'd0, air0}, 1);
    chk("go_y1", {21'd0, y1}, 301);
    for (int k = 1; k <= 8; k++) begin
      push(0, 348, 1'b0, k == 8, 1'b1);
      push(1, 348, 1'b0, k == 8, 1'b1);
    end
    game_over = 1'b0;
    @(negedge clk);
    chk("replay_y0", {21'd0, y0}, 348);
    chk("replay_air0", {31'd0, air0}, 0);
    chk("replay_rf0", {31'd0, rf0}, 0);
    chk("replay_y1", {21'd0, y1}, 348);
    chk("replay_air1", {31'd0, air1}, 0);
    // reset after flight tick 3
    repeat (8) wait_tick();
    pulse_jump();
    push(0, 336, 1'b1, 1'b1, 1'b1);
    push(0, 325, 1'b1, 1'b1, 1'b1);
    push(0, 315, 1'b1, 1'b1, 1'b1);
    push(1, 336, 1'b1, 1'b1, 1'b1);
    push(1, 325, 1'b1, 1'b1, 1'b1);
    push(1, 315, 1'b1, 1'b1, 1'b1);
    repeat (3) wait_tick();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_y0", {21'd0, y0}, 348);
    chk("midrst_air0", {31'd0, air0}, 0);
    chk("midrst_rf0", {31'd0, rf0}, 0);
    chk("midrst_y1", {21'd0, y1}, 348);
    chk("midrst_air1", {31'd0, air1}, 0);
    chk("midrst_rf1", {31'd0, rf1}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // duck pose
    report[5] = 1'b1;
    repeat (4) @(negedge clk);
    chk("duck_on0", {31'd0, dk0}, DK);
    chk("duck_y0", {21'd0, y0}, DY);
    chk("duck_on1", {31'd0, dk1}, DK);
    chk("duck_y1", {21'd0, y1}, DY);
`ifdef DINO_DUCK_EN
    pulse_jump();
    ground(0, 6, DY);
    ground(1, 6, DY);
    repeat (6) wait_tick();
    @(negedge clk);
`endif
    report[5] = 1'b0;
    repeat (2) @(negedge clk);
    chk("duck_hold_y0", {21'd0, y0}, DY);
    @(negedge clk);
    chk("duck_rel_y0", {21'd0, y0}, 348);
    chk("duck_rel_on0", {31'd0, dk0}, 0);
    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
